// File: rtl/cnn_result_streamer.sv
// cnn_result_streamer: captures the pooled CNN map and streams it out one element per valid/ready transfer.
// It also tracks the running maximum element and its index.
module cnn_result_streamer #(
  parameter int In_d_W_Pool = 18,
  parameter int R_Pool_Out = 2,
  parameter int C_Pool_Out = 2,
  localparam int N_El = R_Pool_Out * C_Pool_Out,
  localparam int Idx_W = (N_El > 1) ? $clog2(N_El) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_El*In_d_W_Pool-1:0] Y,
  output logic [In_d_W_Pool-1:0]      out_data,
  output logic [Idx_W-1:0]            out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic [In_d_W_Pool-1:0]      max_val,
  output logic [Idx_W-1:0]            max_idx
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [N_El*In_d_W_Pool-1:0] buf_q, buf_d;
  logic [Idx_W-1:0] idx_q, idx_d, max_idx_q, max_idx_d;
  logic [In_d_W_Pool-1:0] max_val_q, max_val_d;
  logic xfer, last_idx;
  assign out_data = buf_q[int'(idx_q)*In_d_W_Pool +: In_d_W_Pool];
  assign out_idx = idx_q;
  assign out_valid = state_q == STREAM;
  assign last_idx = idx_q == Idx_W'(N_El - 1);
  assign out_last = out_valid && last_idx;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;
  assign xfer = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    idx_d = idx_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    if (state_q == IDLE && start) begin
      state_d = STREAM;
      buf_d = Y;
      idx_d = '0;
      max_val_d = '0;
      max_idx_d = '0;
    end
    if (xfer) begin
      state_d = last_idx ? DONE : STREAM;
      idx_d = last_idx ? '0 : idx_q + Idx_W'(1);
      // element 0 always seeds the max; later ties keep the earlier index
      if (idx_q == '0 || out_data > max_val_q) begin
        max_val_d = out_data;
        max_idx_d = idx_q;
      end
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q <= '0;
      idx_q <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      idx_q <= idx_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end
endmodule

// File: tb/tb_cnn_result_streamer.sv
// tb_cnn_result_streamer: scoreboard bench for the default 2x2 map and a 1x1 map instance.
module tb_cnn_result_streamer;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [71:0] y = '0;
  logic [17:0] out_data, max_val;
  logic [1:0] out_idx, max_idx;
  logic out_valid, out_last, busy, done;
  logic start1 = 0, out_ready1 = 1;
  logic [17:0] y1 = 18'd9, out_data1, max_val1;
  logic [0:0] out_idx1, max_idx1;
  logic out_valid1, out_last1, busy1, done1;
  int checks = 0, errors = 0;
  typedef struct {logic [17:0] d; logic [1:0] i; logic l;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  cnn_result_streamer dut (
    .clk(clk), .rst(rst), .start(start), .Y(y), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .done(done), .max_val(max_val), .max_idx(max_idx)
  );
  cnn_result_streamer #(.R_Pool_Out(1), .C_Pool_Out(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .Y(y1), .out_data(out_data1), .out_idx(out_idx1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1), .busy(busy1),
    .done(done1), .max_val(max_val1), .max_idx(max_idx1)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("sb_avail", q.size(), 1);
      else begin
        chk("out_data", out_data, q[0].d);
        chk("out_idx", out_idx, q[0].i);
        chk("out_last", out_last, q[0].l);
        if (out_ready) void'(q.pop_front());
      end
    end
  end
  task automatic push_frame(input logic [71:0] f, output logic [17:0] mv, output logic [1:0] mi);
    mv = 0;
    mi = 0;
    for (int k = 0; k < 4; k++) begin
      q.push_back('{f[k*18 +: 18], 2'(k), k == 3});
      if (k == 0 || f[k*18 +: 18] > mv) begin
        mv = f[k*18 +: 18];
        mi = 2'(k);
      end
    end
  endtask
  task automatic frame(input logic [71:0] f, input logic [15:0] pat, input int npat, input bit poke);
    logic [17:0] mv;
    logic [1:0] mi;
    int n, nd;
    nd = 5;
    for (int i = 0; i < npat; i++) if (!pat[i]) nd++;
    y = f;
    push_frame(f, mv, mi);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (n = 1; n <= 30; n++) begin
      out_ready = (n - 1 < npat) ? pat[n-1] : 1'b1;
      if (poke && n == 2) begin
        y = {4{18'd1}};
        start = 1;
      end
      if (n == 3) start = 0;
      @(negedge clk);
      if (n == 1) begin
        chk("busy_t1", busy, 1);
        chk("max_cleared", max_val, 0);
        chk("done_low_t1", done, 0);
      end
      if (done) break;
      @(posedge clk);
      #1;
    end
    chk("done_cycle", n, nd);
    chk("valid_in_done", out_valid, 0);
    chk("max_val", max_val, mv);
    chk("max_idx", max_idx, mi);
    @(posedge clk);
    #1 out_ready = 1;
    start = 0;
    y = f;
    chk("sb_drained", q.size(), 0);
  endtask
  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_max_idx", max_idx, 0);
    @(posedge clk);
    #1;
    frame({18'd17, 18'd3, 18'd17, 18'd5}, 16'h0, 0, 0);
    frame({18'd17, 18'd3, 18'd17, 18'd5}, 16'b1101001, 7, 0);
    frame({18'd17, 18'd3, 18'd17, 18'd5}, 16'h0, 0, 1);
    frame({18'h3FFFF, 18'd0, 18'h3FFFF, 18'h3FFFF}, 16'h0, 0, 0);
    frame({18'd4, 18'd2, 18'd8, 18'd8}, 16'b0110, 4, 0);
    frame({18'd0, 18'd0, 18'd0, 18'd0}, 16'h0, 0, 0);
    begin
      logic [17:0] mv;
      logic [1:0] mi;
      y = {18'd11, 18'd22, 18'd33, 18'd44};
      push_frame(y, mv, mi);
      start = 1;
      @(posedge clk);
      #1 start = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      out_ready = 0;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_idx", out_idx, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_max", max_val, 0);
      q.delete();
      @(posedge clk);
      #1 out_ready = 1;
    end
    frame({18'd11, 18'd22, 18'd33, 18'd44}, 16'h0, 0, 0);
    rst = 1;
    start = 1;
    @(posedge clk);
    #1 rst = 0;
    start = 0;
    @(negedge clk);
    chk("rst_wins_busy", busy, 0);
    chk("rst_wins_valid", out_valid, 0);
    @(posedge clk);
    #1 start1 = 1;
    @(posedge clk);
    #1 start1 = 0;
    @(negedge clk);
    chk("n1_valid", out_valid1, 1);
    chk("n1_data", out_data1, 9);
    chk("n1_idx", out_idx1, 0);
    chk("n1_last", out_last1, 1);
    @(negedge clk);
    chk("n1_done", done1, 1);
    chk("n1_valid_done", out_valid1, 0);
    chk("n1_max_val", max_val1, 9);
    chk("n1_max_idx", max_idx1, 0);
    @(negedge clk);
    chk("n1_idle", busy1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_result_streamer.md
# cnn_result_streamer

Reads the flattened pooled feature map produced by the CNN layer (conv → ReLU → max-pool) and delivers it one element per transfer over a valid/ready stream. Also tracks the largest element and its position for a classification decision. Sits directly downstream of the CNN layer's parallel `Y` output. It is the reader for that wide bus, turning it into a narrow stream for the next layer, a FIFO, or a host interface.

## Interface
- `In_d_W_Pool`, 18, width of one pooled element (unsigned; post-ReLU values are non-negative).
- `R_Pool_Out`, 2, rows of the pooled map.
- `C_Pool_Out`, 2, columns of the pooled map.
- `N_El` (localparam) = `R_Pool_Out*C_Pool_Out`.
- `Idx_W` (localparam) = max(1, clog2(`N_El`)).

Ports:
- `clk` input 1 — single clock; all logic is rising-edge.
- `rst` input 1 — synchronous, active-high reset.
- `start` input 1 — capture `Y` and begin streaming; honoured only in IDLE.
- `Y` input `N_El*In_d_W_Pool` — pooled map. Element k = r*`C_Pool_Out`+c occupies bits [(k+1)*`In_d_W_Pool`-1 : k*`In_d_W_Pool`].
- `out_data` output `In_d_W_Pool` — current element.
- `out_idx` output `Idx_W` — index k of `out_data`.
- `out_valid` output 1 — `out_data`/`out_idx`/`out_last` are valid.
- `out_ready` input 1 — consumer accepts the element when high with `out_valid`.
- `out_last` output 1 — high with the element k = `N_El`-1.
- `busy` output 1 — high whenever the state is not IDLE.
- `done` output 1 — one-cycle pulse after the final transfer.
- `max_val` output `In_d_W_Pool` — largest transferred element; valid when `done` is high, then held.
- `max_idx` output `Idx_W` — index of `max_val`.

## Operation
- The FSM has three states: IDLE, STREAM, DONE.
- IDLE:
  - `start`=1 → register all of `Y` into an internal buffer, set idx=0, clear the running max (value 0, index 0), and go to STREAM.
  - `Y` is not sampled at any other time, so later changes on `Y` have no effect.
- STREAM:
  - `out_valid`=1 and `out_data`=buffer[idx].
  - A transfer occurs on a cycle where `out_valid`&&`out_ready` is high. On a transfer, idx increments.
  - On a transfer at idx=`N_El`-1, go to DONE.
  - With no transfer, `out_data`, `out_idx` and `out_last` hold stable (standard valid/ready rule). `out_valid` never drops before the transfer completes.
- Running max:
  - Updated on each transfer when the element is strictly greater than the current max, or when it is element 0.
  - Ties keep the lower index.
  - All zeros → `max_val`=0, `max_idx`=0.
- DONE: lasts one cycle. `done`=1 and `out_valid`=0, then the FSM returns to IDLE.
- `start` in STREAM or DONE is ignored; there is no queuing.
- `max_val`/`max_idx` hold their values until the next accepted `start` clears them.
- `N_El`=1 → a single transfer with `out_last`=1, then DONE.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_last`=0, `out_data`=0, `out_idx`=0, `busy`=0, `done`=0, `max_val`=0, `max_idx`=0, buffer cleared.
- `rst` in any state returns to IDLE on that edge. An in-flight frame is discarded, and neither `done` nor `out_last` is produced.
- `rst` and `start` high together: reset wins.
- `start` sampled high at edge t → `out_valid`=1 with element 0 from cycle t+1. `busy` is high from t+1.
- With `out_ready` held at 1: one element per cycle, last element in cycle t+`N_El`, `done` in cycle t+`N_El`+1, IDLE at t+`N_El`+2.
- The earliest next accepted `start` is sampled at edge t+`N_El`+2.
- Every `out_ready` low cycle during STREAM stretches the frame by exactly one cycle.
- `out_valid` and `out_data` are registered; there is no combinational path from `out_ready` to any output.

## Test plan
- Default parameters, `Y` elements k0..k3 = {5, 17, 3, 17}, `start` pulse, `out_ready`=1 → outputs 5, 17, 3, 17 with `out_idx` 0..3, `out_last` only on idx 3, `done` at t+5, `max_val`=17, `max_idx`=1.
- Same frame, `out_ready` toggling 1,0,0,1,0,1,1 → no element duplicated or dropped, `out_data` stable during stalls, `done` delayed by 3 cycles versus the first case.
- Change `Y` to {1, 1, 1, 1} during STREAM → the stream still carries {5, 17, 3, 17}. `start` during STREAM is ignored and the idx sequence is unchanged.
- `Y` all 0x3FFFF, except element 2 = 0 → `max_val`=0x3FFFF, `max_idx`=0. Back-to-back frames: a second `start` at t+6 is accepted and `max_val` clears before its stream.
- `rst` asserted after 2 transfers → next cycle all outputs at reset values, no `done`. A new `start` streams a full frame from idx 0.
- `R_Pool_Out`=1, `C_Pool_Out`=1, `Y`=9 → single transfer with `out_last`=1, `done` at t+2, `max_val`=9, `max_idx`=0.
